// File: rtl/uart_rx_ctl.sv
// UART receive controller: synchronizes rxd, samples 8N1 frames at mid-bit on the
// shared 16x enable, and reports each character with a ready or framing-error strobe.
module uart_rx_ctl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_rx,
    input  logic       rst_clk_rx_n,
    input  logic       baud_x16_en,
    input  logic       rxd_i,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       frm_err,
    output logic       rx_store_qual,
    output logic [1:0] rx_frame_indicator,
    output logic       rx_bit_indicator
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       rdy_q, rdy_d;
    logic       err_q, err_d;
    logic [1:0] frame_ind_q, frame_ind_d;
    logic [1:0] frame_old_q, frame_old_d;

    // Metastability chain runs every clock; only the last stage is used by the FSM.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
            frame_ind_q <= 2'b00;
            frame_old_q <= 2'b10;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
            frame_ind_q <= frame_ind_d;
            frame_old_q <= frame_old_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rdy_d       = 1'b0;
        err_d       = 1'b0;
        frame_ind_d = frame_ind_q;
        frame_old_d = frame_old_q;

        if (baud_x16_en) begin
            case (state_q)
                StIdle: begin
                    if (!rxd_s) begin
                        state_d     = StStart;
                        cnt_d       = 4'd7;
                        frame_ind_d = ~frame_old_q;
                        frame_old_d = ~frame_old_q;
                    end
                end
                StStart: begin
                    if (cnt_q == 4'd0) begin
                        if (!rxd_s) begin
                            state_d   = StData;
                            cnt_d     = 4'd15;
                            bit_cnt_d = 3'd0;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            state_d     = StIdle;
                            frame_ind_d = 2'b00;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StData: begin
                    if (cnt_q == 4'd0) begin
                        shift_d[bit_cnt_q] = rxd_s;
                        cnt_d              = 4'd15;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StStop: begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught.
                    if (cnt_q == 4'd0) begin
                        state_d     = StIdle;
                        frame_ind_d = 2'b00;
                        if (rxd_s) begin
                            data_d = shift_q;
                            rdy_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign rx_data            = data_q;
    assign rx_data_rdy        = rdy_q;
    assign frm_err            = err_q;
    assign rx_frame_indicator = frame_ind_q;
    assign rx_store_qual      = (frame_ind_q != 2'b00);
    assign rx_bit_indicator   = (cnt_q == 4'd0) && (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctl.sv
// Self-checking bench for uart_rx_ctl: scoreboard of expected characters/framing errors
// checked by a monitor, plus per-scenario inline checks of strobes, indicators and timing.
module tb_uart_rx_ctl;

    logic       clk_rx;
    logic       rst_clk_rx_n;
    logic       baud_x16_en;
    logic       rxd_i;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       frm_err;
    logic       rx_store_qual;
    logic [1:0] rx_frame_indicator;
    logic       rx_bit_indicator;

    uart_rx_ctl #(.SYNC_STAGES(2)) dut (
        .clk_rx             (clk_rx),
        .rst_clk_rx_n       (rst_clk_rx_n),
        .baud_x16_en        (baud_x16_en),
        .rxd_i              (rxd_i),
        .rx_data            (rx_data),
        .rx_data_rdy        (rx_data_rdy),
        .frm_err            (frm_err),
        .rx_store_qual      (rx_store_qual),
        .rx_frame_indicator (rx_frame_indicator),
        .rx_bit_indicator   (rx_bit_indicator)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_cnt  = 0;
    int err_cnt  = 0;
    int samp_cnt = 0;
    int bit_rise = 0;
    int rdy_times[$];
    int samp_times[$];
    logic rdy_prev = 1'b0;
    logic err_prev = 1'b0;
    logic bit_prev = 1'b0;

    // Reference model state
    logic [1:0] frame_old_m;
    logic [7:0] data_m;

    initial begin
        clk_rx = 1'b0;
        forever #5 clk_rx = ~clk_rx;
    end

    // One-cycle enable every 4 clocks, changed away from both edges.
    initial begin
        logic [1:0] div;
        div = 2'd0;
        baud_x16_en = 1'b0;
        forever begin
            @(posedge clk_rx);
            #2;
            div = div + 2'd1;
            baud_x16_en = (div == 2'd3);
        end
    end

    // Monitor: pops the scoreboard on every strobe and records timing.
    initial begin
        forever begin
            @(negedge clk_rx);
            cyc++;
            if (rx_data_rdy) begin
                rdy_cnt++;
                rdy_times.push_back(cyc);
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_rdy: got unexpected rx_data_rdy with data %h, expected none",
                             rx_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.err !== 1'b0 || rx_data !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL sb_rdy: got ready with data %h, expected err=%0b data %h",
                                 rx_data, mon_e.err, mon_e.data);
                    end
                end
                n_checks++;
                if (rdy_prev !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rdy_width: rdy high on consecutive cycles, prev=%b expected 0",
                             rdy_prev);
                end
            end
            if (frm_err) begin
                err_cnt++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_err: got unexpected frm_err, expected none");
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.err !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_err: got frm_err, expected ready with data %h",
                                 mon_e.data);
                    end
                end
                n_checks++;
                if (err_prev !== 1'b0) begin
                    n_fail++;
                    $display("FAIL err_width: frm_err high on consecutive cycles, prev=%b expected 0",
                             err_prev);
                end
            end
            if (rx_bit_indicator && baud_x16_en) begin
                samp_cnt++;
                samp_times.push_back(cyc);
            end
            if (rx_bit_indicator && !bit_prev) bit_rise++;
            rdy_prev = rx_data_rdy;
            err_prev = frm_err;
            bit_prev = rx_bit_indicator;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (rx_frame_indicator !== 2'b00 || rx_store_qual !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: got ind=%b qual=%b, expected ind=00 qual=0",
                     name, rx_frame_indicator, rx_store_qual);
        end
    endtask

    // Sends one 8N1 frame (16 ticks = 64 clocks per bit) and queues the expected outcome.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t       e;
        logic [1:0] ind_exp;
        ind_exp     = ~frame_old_m;
        frame_old_m = ind_exp;
        e.err       = ~stop;
        e.data      = stop ? d : 8'h00;
        sb_q.push_back(e);
        if (stop) data_m = d;
        rxd_i = 1'b0;
        wait_clks(64);
        for (int i = 0; i < 8; i++) begin
            rxd_i = d[i];
            wait_clks(32);
            if (i == 1) begin
                n_checks++;
                if (rx_frame_indicator !== ind_exp || rx_store_qual !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_ind: got ind=%b qual=%b, expected ind=%b qual=1",
                             rx_frame_indicator, rx_store_qual, ind_exp);
                end
            end
            wait_clks(32);
        end
        rxd_i = stop;
        wait_clks(64);
        if (!stop) begin
            // Low line at mid-stop restarts a frame that then aborts as a glitch.
            frame_old_m = ~frame_old_m;
            rxd_i = 1'b1;
        end
    endtask

    task automatic check_counts(input string name, input int rc0, input int ec0,
                                input int drdy, input int derr);
        n_checks++;
        if (rdy_cnt - rc0 !== drdy || err_cnt - ec0 !== derr) begin
            n_fail++;
            $display("FAIL %s_counts: got rdy=%0d err=%0d, expected rdy=%0d err=%0d",
                     name, rdy_cnt - rc0, err_cnt - ec0, drdy, derr);
        end
        n_checks++;
        if (rx_data !== data_m) begin
            n_fail++;
            $display("FAIL %s_data: got rx_data=%h, expected %h", name, rx_data, data_m);
        end
    endtask

    task automatic test_reset();
        wait_clks(5);
        n_checks++;
        if (rx_data !== 8'h00 || rx_data_rdy !== 1'b0 || frm_err !== 1'b0 ||
            rx_frame_indicator !== 2'b00 || rx_store_qual !== 1'b0 || rx_bit_indicator !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: got data=%h rdy=%b err=%b ind=%b qual=%b bit=%b, expected all 0",
                     rx_data, rx_data_rdy, frm_err, rx_frame_indicator, rx_store_qual,
                     rx_bit_indicator);
        end
        rst_clk_rx_n = 1'b1;
        wait_clks(20);
        check_idle("reset");
    endtask

    task automatic test_single();
        int rc0 = rdy_cnt;
        int ec0 = err_cnt;
        send_frame(8'hA5, 1'b1);
        wait_clks(64);
        check_counts("single", rc0, ec0, 1, 0);
        n_checks++;
        if (rx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_value: got rx_data=%h, expected a5", rx_data);
        end
        check_idle("single");
    endtask

    task automatic test_glitch();
        int rc0 = rdy_cnt;
        int ec0 = err_cnt;
        logic [1:0] ind_exp;
        ind_exp     = ~frame_old_m;
        frame_old_m = ind_exp;
        rxd_i = 1'b0;
        wait_clks(12);
        n_checks++;
        if (rx_frame_indicator !== ind_exp) begin
            n_fail++;
            $display("FAIL glitch_ind: got ind=%b, expected %b", rx_frame_indicator, ind_exp);
        end
        wait_clks(8);
        rxd_i = 1'b1;
        wait_clks(64);
        check_counts("glitch", rc0, ec0, 0, 0);
        check_idle("glitch");
    endtask

    task automatic test_frame_error();
        int rc0 = rdy_cnt;
        int ec0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        wait_clks(96);
        check_counts("frmerr", rc0, ec0, 0, 1);
        check_idle("frmerr");
    endtask

    task automatic test_back_to_back();
        int rc0 = rdy_cnt;
        int ec0 = err_cnt;
        rdy_times.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(64);
        check_counts("b2b", rc0, ec0, 2, 0);
        n_checks++;
        if (rdy_times.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d ready pulses, expected 2", rdy_times.size());
        end else if (rdy_times[1] - rdy_times[0] != 640) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d clocks between ready pulses, expected 640",
                     rdy_times[1] - rdy_times[0]);
        end
        check_idle("b2b");
    endtask

    task automatic test_bit_indicator();
        samp_cnt = 0;
        bit_rise = 0;
        samp_times.delete();
        send_frame(8'h96, 1'b1);
        wait_clks(64);
        n_checks++;
        if (samp_cnt != 10 || bit_rise != 10) begin
            n_fail++;
            $display("FAIL bit_ind_count: got samples=%0d pulses=%0d, expected 10 and 10",
                     samp_cnt, bit_rise);
        end
        for (int i = 1; i < samp_times.size(); i++) begin
            n_checks++;
            if (samp_times[i] - samp_times[i-1] != 64) begin
                n_fail++;
                $display("FAIL bit_ind_spacing: got %0d clocks before sample %0d, expected 64",
                         samp_times[i] - samp_times[i-1], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rc0;
        int ec0;
        logic [7:0] d;
        d = 8'hC3;
        rxd_i = 1'b0;
        wait_clks(64);
        for (int i = 0; i < 4; i++) begin
            rxd_i = d[i];
            wait_clks(64);
        end
        rxd_i = d[4];
        wait_clks(32);
        #2;
        rst_clk_rx_n = 1'b0;
        #1;
        n_checks++;
        if (rx_data !== 8'h00 || rx_data_rdy !== 1'b0 || frm_err !== 1'b0 ||
            rx_frame_indicator !== 2'b00 || rx_store_qual !== 1'b0 || rx_bit_indicator !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got data=%h rdy=%b err=%b ind=%b qual=%b bit=%b, expected all 0",
                     rx_data, rx_data_rdy, frm_err, rx_frame_indicator, rx_store_qual,
                     rx_bit_indicator);
        end
        rxd_i       = 1'b1;
        frame_old_m = 2'b10;
        data_m      = 8'h00;
        wait_clks(10);
        rst_clk_rx_n = 1'b1;
        wait_clks(20);
        rc0 = rdy_cnt;
        ec0 = err_cnt;
        send_frame(8'h5A, 1'b1);
        wait_clks(64);
        check_counts("rstmid", rc0, ec0, 1, 0);
        check_idle("rstmid");
    endtask

    initial begin
        rst_clk_rx_n = 1'b0;
        rxd_i        = 1'b1;
        frame_old_m  = 2'b10;
        data_m       = 8'h00;
        test_reset();
        test_single();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_bit_indicator();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding expected results, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
